// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 pipeline types: forward selects, ALU ops, control bundle
package cpu_pkg;

   localparam logic [2:0] FWD_RF  = 3'b000;
   localparam logic [2:0] FWD_EX  = 3'b001;
   localparam logic [2:0] FWD_MEM = 3'b010;
   localparam logic [2:0] FWD_WR  = 3'b011;

   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [2:0] {
      ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_EOR, ALU_LSL, ALU_LSR
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      logic    set_flags;
      alu_op_e alu_op;
   } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - 4-way operand select between regfile data and forwarded results
module fwd_mux
   import cpu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      sel,
   input  logic [XLEN-1:0] rf_data,
   input  logic [XLEN-1:0] ex_data,
   input  logic [XLEN-1:0] mem_alu,
   input  logic [XLEN-1:0] mem_load,
   input  logic            mem_is_load,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] y
);

   // Encodings with the top bit set fall back to the regfile value.
   always_comb begin
      y = rf_data;
      case (sel)
         FWD_EX:  y = ex_data;
         FWD_MEM: y = mem_is_load ? mem_load : mem_alu;
         FWD_WR:  y = wr_data;
         default: y = rf_data;
      endcase
   end

endmodule

// File: rtl/dec_ex_stage.sv
// rtl/dec_ex_stage.sv - DEC/EX pipeline register with forwarding, load-use stall and flush
// Optional macro STALL_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module dec_ex_stage
   import cpu_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int XLEN              = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_DEC,
   input  logic [4:0]      Rn_DEC,
   input  logic [4:0]      Rm_DEC,
   input  logic [4:0]      Rd_DEC,
   input  logic            UsesRm_DEC,
   input  logic [XLEN-1:0] Da_DEC,
   input  logic [XLEN-1:0] Db_DEC,
   input  logic [XLEN-1:0] Imm_DEC,
   input  logic            RegWrite_DEC,
   input  logic            MemRead_DEC,
   input  logic            MemWrite_DEC,
   input  logic            MemToReg_DEC,
   input  logic            ALUSrc_DEC,
   input  logic            SetFlags_DEC,
   input  logic [2:0]      ALUOp_DEC,
   input  logic [2:0]      FwdScA,
   input  logic [2:0]      FwdScB,
   input  logic [XLEN-1:0] ALUResult_EX,
   input  logic [XLEN-1:0] ALUResult_MEM,
   input  logic [XLEN-1:0] MemData_MEM,
   input  logic [XLEN-1:0] Dw_WR,
   input  logic            MemRead_MEM,
   input  logic            flush,
   output logic            valid_EX,
   output logic [4:0]      Rn_EX,
   output logic [4:0]      Rd_EX,
   output logic [XLEN-1:0] OpA_EX,
   output logic [XLEN-1:0] OpB_EX,
   output logic [XLEN-1:0] Imm_EX,
   output logic            RegWrite_EX,
   output logic            MemRead_EX,
   output logic            MemWrite_EX,
   output logic            MemToReg_EX,
   output logic            ALUSrc_EX,
   output logic            SetFlags_EX,
   output logic [2:0]      ALUOp_EX,
   output logic            stall_DEC
`ifdef STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   typedef enum logic {RUN, STALL} state_e;

   localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

   state_e          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            hz, bubble;
   ctrl_t           ctrl_dec, ctrl_q;
   logic [XLEN-1:0] opa, opb;

   fwd_mux #(.XLEN(XLEN)) u_fwd_a (
      .sel(FwdScA), .rf_data(Da_DEC), .ex_data(ALUResult_EX), .mem_alu(ALUResult_MEM),
      .mem_load(MemData_MEM), .mem_is_load(MemRead_MEM), .wr_data(Dw_WR), .y(opa)
   );

   fwd_mux #(.XLEN(XLEN)) u_fwd_b (
      .sel(FwdScB), .rf_data(Db_DEC), .ex_data(ALUResult_EX), .mem_alu(ALUResult_MEM),
      .mem_load(MemData_MEM), .mem_is_load(MemRead_MEM), .wr_data(Dw_WR), .y(opb)
   );

   assign ctrl_dec = '{reg_write: RegWrite_DEC, mem_read: MemRead_DEC, mem_write: MemWrite_DEC,
                       mem_to_reg: MemToReg_DEC, alu_src: ALUSrc_DEC, set_flags: SetFlags_DEC,
                       alu_op: alu_op_e'(ALUOp_DEC)};

   assign hz = valid_DEC & valid_EX & ctrl_q.mem_read & (Rd_EX != XZR) &
               ((Rn_DEC == Rd_EX) | (UsesRm_DEC & (Rm_DEC == Rd_EX)));

   // STALL with an exhausted counter behaves exactly like RUN for that cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_DEC = 1'b0;
      bubble    = 1'b0;
      if (flush) begin
         bubble  = 1'b1;
         state_d = RUN;
         cnt_d   = 2'd0;
      end else if (state_q == STALL && cnt_q != 2'd0) begin
         stall_DEC = 1'b1;
         bubble    = 1'b1;
         cnt_d     = cnt_q - 2'd1;
      end else if (hz) begin
         stall_DEC = 1'b1;
         bubble    = 1'b1;
         cnt_d     = STALL_INIT;
         state_d   = (STALL_INIT == 2'd0) ? RUN : STALL;
      end else begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= RUN;
         cnt_q    <= 2'd0;
         valid_EX <= 1'b0;
         Rn_EX    <= '0;
         Rd_EX    <= '0;
         OpA_EX   <= '0;
         OpB_EX   <= '0;
         Imm_EX   <= '0;
         ctrl_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (bubble) begin
            valid_EX <= 1'b0;
            Rn_EX    <= '0;
            Rd_EX    <= '0;
            OpA_EX   <= '0;
            OpB_EX   <= '0;
            Imm_EX   <= '0;
            ctrl_q   <= '0;
         end else begin
            valid_EX <= valid_DEC;
            Rn_EX    <= Rn_DEC;
            Rd_EX    <= Rd_DEC;
            OpA_EX   <= opa;
            OpB_EX   <= opb;
            Imm_EX   <= Imm_DEC;
            ctrl_q   <= valid_DEC ? ctrl_dec : '0;
         end
      end
   end

   assign RegWrite_EX = ctrl_q.reg_write;
   assign MemRead_EX  = ctrl_q.mem_read;
   assign MemWrite_EX = ctrl_q.mem_write;
   assign MemToReg_EX = ctrl_q.mem_to_reg;
   assign ALUSrc_EX   = ctrl_q.alu_src;
   assign SetFlags_EX = ctrl_q.set_flags;
   assign ALUOp_EX    = 3'(ctrl_q.alu_op);

`ifdef STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_DEC && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
         if (flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule
